// File: rtl/fifo.sv
// Synchronous single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and one-cycle overflow/underflow pulses. Read data is registered
// (one cycle after rd_en); there is no fall-through when empty.
module fifo #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int AFULL_LVL  = DEPTH - 1,
   parameter int AEMPTY_LVL = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,        // synchronous, active-high
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL  = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AE_LVL  = CW'(AEMPTY_LVL);
   localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic             wr_acc, rd_acc;

   // Status is derived from the registered count only
   assign full         = (count_q == CNT_MAX);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_LVL);
   assign almost_empty = (count_q <= AE_LVL);
   assign count        = count_q;
   assign rd_data      = rd_data_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // A read frees a slot in the same cycle, so a full FIFO can still take a write
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   // Next-state: pointer wrap at DEPTH-1 (DEPTH need not be a power of two)
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      ovf_d     = wr_en && !wr_acc;
      udf_d     = rd_en && !rd_acc;
      if (wr_acc)
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) begin
         rd_ptr_d  = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
         rd_data_d = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and output registers; reset discards contents
   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   // Storage array: written on accepted writes, never cleared
   always_ff @(posedge clk) begin
      if (!rst_n && wr_acc)
         mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a queue model tracks contents, expected read data is
// pushed to a scoreboard when a read is issued and popped when rd_data updates.
module tb_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] rd_data;
   logic             full, empty, almost_full, almost_empty, overflow, underflow;
   logic [CW-1:0]    count;

   int n_chk = 0;
   int n_err = 0;

   logic [WIDTH-1:0] mdl[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] last_rd = '0;

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .full(full), .empty(empty), .count(count),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_status(input string tag, input bit ovf, input bit udf);
      int n;
      n = mdl.size();
      chk({tag, ".count"},  32'(count), 32'(n));
      chk({tag, ".full"},   32'(full), 32'(n == DEPTH));
      chk({tag, ".empty"},  32'(empty), 32'(n == 0));
      chk({tag, ".afull"},  32'(almost_full), 32'(n >= DEPTH - 1));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
      chk({tag, ".ovf"},    32'(overflow), 32'(ovf));
      chk({tag, ".udf"},    32'(underflow), 32'(udf));
      chk({tag, ".rdata"},  32'(rd_data), 32'(last_rd));
   endtask

   // One clock with the given request; model updated, outputs checked #1 after the edge
   task automatic op(input string tag, input bit w, input logic [WIDTH-1:0] d, input bit r);
      bit racc, wacc;
      racc = r && (mdl.size() != 0);
      wacc = w && ((mdl.size() != DEPTH) || racc);
      if (racc) exp_q.push_back(mdl.pop_front());
      if (wacc) mdl.push_back(d);
      wr_en = w; wr_data = d; rd_en = r;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      if (racc) last_rd = exp_q.pop_front();
      chk_status(tag, w && !wacc, r && !racc);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      mdl.delete(); exp_q.delete(); last_rd = '0;
      chk_status(tag, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset
      do_reset("reset");
      // Fill 1..8 (almost_full at 7, full at 8)
      for (int i = 1; i <= DEPTH; i++) op("fill", 1'b1, WIDTH'(i), 1'b0);
      // Drain in order
      for (int i = 1; i <= DEPTH; i++) op("drain", 1'b0, '0, 1'b1);
      chk("drain.last", 32'(rd_data), 32'h8);
      // Overflow: write 0xAA while full is dropped
      for (int i = 0; i < DEPTH; i++) op("refill", 1'b1, WIDTH'(16'h20 + i), 1'b0);
      op("ovf", 1'b1, 16'h00AA, 1'b0);
      op("ovf.clear", 1'b0, '0, 1'b0);
      for (int i = 0; i < DEPTH; i++) op("drain2", 1'b0, '0, 1'b1);
      chk("drain2.last", 32'(rd_data), 32'h27);
      // Underflow: read on empty holds rd_data
      op("udf", 1'b0, '0, 1'b1);
      op("udf.clear", 1'b0, '0, 1'b0);
      // Simultaneous at full: count stays 8, 0x0009 read last
      for (int i = 1; i <= DEPTH; i++) op("fill3", 1'b1, WIDTH'(i), 1'b0);
      op("both.full", 1'b1, 16'h0009, 1'b1);
      for (int i = 0; i < DEPTH; i++) op("drain3", 1'b0, '0, 1'b1);
      chk("drain3.last", 32'(rd_data), 32'h9);
      // Simultaneous at empty: write only, underflow pulse
      op("both.empty", 1'b1, 16'h0055, 1'b1);
      op("drain4", 1'b0, '0, 1'b1);
      // Wrap: 20 interleaved ops crossing pointer wrap
      for (int i = 0; i < 20; i++)
         op("wrap", (i % 4) != 3, WIDTH'(16'h100 + i), (i % 3) != 0);
      while (mdl.size() != 0) op("wrap.drain", 1'b0, '0, 1'b1);
      // Mid-operation reset with count=5
      for (int i = 0; i < 5; i++) op("pre_rst", 1'b1, WIDTH'(16'h300 + i), 1'b0);
      chk("pre_rst.count", 32'(count), 32'd5);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      mdl.delete(); exp_q.delete(); last_rd = '0;
      chk_status("mid_rst", 1'b0, 1'b0);
      op("post_rst.rd", 1'b0, '0, 1'b1);
      op("post_rst.wr", 1'b1, 16'h0777, 1'b0);
      op("post_rst.rd2", 1'b0, '0, 1'b1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
